fcp6_slave: RTL

FCP6_SLAVE -- requirements
Module: fcp6_slave

---
 rtl/fcp6_pkg.sv | 25 ++
 rtl/fcp6_dibit_shifter.sv | 35 +++
 rtl/fcp6_slave.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fcp6_pkg.sv
// Shared definitions for the FCP6 dibit-bus responder: ownership codes,
// acknowledge levels and the responder's state encoding.
package fcp6_pkg;

    localparam logic [1:0] CTRL_MASTER = 2'b01;
    localparam logic [1:0] CTRL_SLAVE  = 2'b10;
    localparam logic [1:0] CTRL_END    = 2'b11;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        ADDR_ACK,
        RX_DATA,
        WAIT_END,
        DATA_ACK,
        TURN,
        TX_DATA,
        WAIT_MACK,
        END
    } slave_state_e;

endpackage

// File: rtl/fcp6_dibit_shifter.sv
// 8-bit MSB-first dibit shift register with a 2-bit dibit index; shared by
// the header, receive and transmit paths of the responder.
module fcp6_dibit_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [7:0] load_val_i,
    input  logic [1:0] din_i,
    output logic [7:0] value_o,
    output logic [1:0] idx_o
);

    logic [7:0] value_q;
    logic [1:0] idx_q;

    // Shifting out for transmit uses the same path with din_i tied to zero.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            value_q <= 8'h00;
            idx_q   <= 2'd0;
        end else if (load_i) begin
            value_q <= load_val_i;
            idx_q   <= 2'd0;
        end else if (shift_i) begin
            value_q <= {value_q[5:0], din_i};
            idx_q   <= idx_q + 2'd1;
        end
    end

    assign value_o = value_q;
    assign idx_o   = idx_q;

endmodule

// File: rtl/fcp6_slave.sv
// FCP6 bus responder: decodes a 4-dibit header, then receives a byte (write)
// or returns tx_data_in (read) over a shared tri-state dibit bus.
module fcp6_slave
    import fcp6_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h4C,
    parameter int         TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire  [1:0] data,
    inout  wire        ack,
    inout  wire  [1:0] ctrl,
    input  logic [7:0] tx_data_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rd_done,
    output logic       err,
    output logic       busy
);

    localparam logic [3:0] WAIT_LIMIT = 4'(TIMEOUT);

    slave_state_e state_q, state_d;
    logic [3:0]   wait_cnt_q, wait_cnt_d;
    logic [7:0]   rx_data_q, rx_data_d;
    logic         rx_valid_q, rx_valid_d;
    logic         rd_done_q, rd_done_d;
    logic         err_q, err_d;
    logic         busy_q, busy_d;
    logic         data_oe_q, data_oe_d;
    logic [1:0]   data_out_q, data_out_d;
    logic         ack_oe_q, ack_oe_d;
    logic         ack_out_q, ack_out_d;
    logic         ctrl_oe_q, ctrl_oe_d;
    logic [1:0]   ctrl_out_q, ctrl_out_d;

    logic         sh_clear, sh_load, sh_shift;
    logic [1:0]   sh_din;
    logic [7:0]   sh_value;
    logic [1:0]   sh_idx;
    logic [6:0]   hdr_addr;

    fcp6_dibit_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (sh_clear),
        .load_i     (sh_load),
        .shift_i    (sh_shift),
        .load_val_i (tx_data_in),
        .din_i      (sh_din),
        .value_o    (sh_value),
        .idx_o      (sh_idx)
    );

    // Address bits as they will stand once the dibit on the bus is shifted in,
    // so the ack value can be registered in time for the ADDR_ACK cycle.
    assign hdr_addr = {sh_value[5:0], data[1]};

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 4'd0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rd_done_d  = 1'b0;
        err_d      = 1'b0;
        data_oe_d  = 1'b0;
        data_out_d = 2'b00;
        ack_oe_d   = 1'b0;
        ack_out_d  = NACK;
        ctrl_oe_d  = 1'b0;
        ctrl_out_d = CTRL_SLAVE;
        sh_clear   = 1'b0;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        sh_din     = data;

        case (state_q)
            IDLE: begin
                if (ctrl == CTRL_MASTER) begin
                    sh_shift = 1'b1;
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (ctrl != CTRL_MASTER) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    sh_shift = 1'b1;
                    if (sh_idx == 2'd3) begin
                        state_d   = ADDR_ACK;
                        ack_oe_d  = 1'b1;
                        ack_out_d = (hdr_addr == SLAVE_ADDR) ? ACK : NACK;
                    end
                end
            end
            ADDR_ACK: begin
                if (sh_value[7:1] != SLAVE_ADDR) begin
                    state_d = IDLE;
                end else if (sh_value[0]) begin
                    state_d = RX_DATA;
                end else begin
                    sh_load = 1'b1;
                    state_d = TURN;
                end
            end
            RX_DATA: begin
                if (ctrl != CTRL_MASTER) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    sh_shift = 1'b1;
                    if (sh_idx == 2'd3) begin
                        state_d = WAIT_END;
                    end
                end
            end
            WAIT_END: begin
                if (ctrl == CTRL_END) begin
                    state_d    = DATA_ACK;
                    ack_oe_d   = 1'b1;
                    ack_out_d  = ACK;
                    rx_data_d  = sh_value;
                    rx_valid_d = 1'b1;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            DATA_ACK: begin
                state_d = IDLE;
            end
            TURN: begin
                state_d    = TX_DATA;
                data_oe_d  = 1'b1;
                data_out_d = sh_value[7:6];
                ctrl_oe_d  = 1'b1;
                sh_shift   = 1'b1;
                sh_din     = 2'b00;
            end
            TX_DATA: begin
                // Index wraps to zero once the fourth dibit is on the bus.
                if (sh_idx == 2'd0) begin
                    state_d = WAIT_MACK;
                end else begin
                    data_oe_d  = 1'b1;
                    data_out_d = sh_value[7:6];
                    ctrl_oe_d  = 1'b1;
                    sh_shift   = 1'b1;
                    sh_din     = 2'b00;
                end
            end
            WAIT_MACK: begin
                if (ack == 1'b1) begin
                    state_d    = END;
                    ctrl_oe_d  = 1'b1;
                    ctrl_out_d = CTRL_END;
                    rd_done_d  = 1'b1;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            sh_clear = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            data_oe_q  <= 1'b0;
            data_out_q <= 2'b00;
            ack_oe_q   <= 1'b0;
            ack_out_q  <= NACK;
            ctrl_oe_q  <= 1'b0;
            ctrl_out_q <= CTRL_SLAVE;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rd_done_q  <= rd_done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            data_oe_q  <= data_oe_d;
            data_out_q <= data_out_d;
            ack_oe_q   <= ack_oe_d;
            ack_out_q  <= ack_out_d;
            ctrl_oe_q  <= ctrl_oe_d;
            ctrl_out_q <= ctrl_out_d;
        end
    end

    assign data = data_oe_q ? data_out_q : 2'bzz;
    assign ack  = ack_oe_q  ? ack_out_q  : 1'bz;
    assign ctrl = ctrl_oe_q ? ctrl_out_q : 2'bzz;

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rd_done  = rd_done_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule
